// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state and forwarding-select encodings for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int WAIT_W = 3;

    typedef enum logic {
        RUN,
        MEMWAIT
    } state_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_ALU = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

endpackage

// File: rtl/pipe_ctrl_fwd.sv
// pipe_ctrl_fwd: single-operand forward selector, MEM result beats WB result, x0 never forwards.
module pipe_ctrl_fwd
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_wr,
    input  logic                  wb_wr,
    output logic [1:0]            sel
);

    always_comb
        sel = (mem_wr && mem_rd != '0 && mem_rd == rs) ? FWD_ALU :
              (wb_wr && wb_rd != '0 && wb_rd == rs)    ? FWD_WB  : FWD_REG;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline hazard/stall/flush controller with memory-latency freeze,
// operand forwarding and retire/stall performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 0,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  if_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  mem_access,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  valid_id,
    output logic                  valid_ex,
    output logic                  valid_mem,
    output logic                  valid_wb,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam bit HAS_LAT = (MEM_LAT > 0);
    localparam logic [WAIT_W-1:0] WAIT_INIT = HAS_LAT ? WAIT_W'(MEM_LAT - 1) : '0;

    state_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              wait_hold;
    logic              frozen;
    logic              branch;
    logic              load_use;
    logic              lu_stall;

    // The cycle that detects a memory access is itself the first frozen cycle.
    always_comb begin
        mem_stall   = HAS_LAT && state == RUN && valid_mem && mem_access;
        wait_hold   = state == MEMWAIT && wait_cnt != '0;
        frozen      = !enable || mem_stall || wait_hold;
        branch      = !frozen && valid_ex && ex_branch_taken;
        load_use    = state == RUN && valid_ex && ex_mem_read && valid_id && ex_rd != '0 &&
                      ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
        lu_stall    = !frozen && !branch && load_use;
        pc_en       = !frozen && !lu_stall;
        if_id_en    = !frozen && !lu_stall;
        id_ex_en    = !frozen;
        ex_mem_en   = !frozen;
        mem_wb_en   = !frozen;
        if_id_flush = branch;
        id_ex_flush = branch || lu_stall;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            valid_id    <= 1'b0;
            valid_ex    <= 1'b0;
            valid_mem   <= 1'b0;
            valid_wb    <= 1'b0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else if (enable) begin
            state    <= (mem_stall || wait_hold) ? MEMWAIT : RUN;
            wait_cnt <= mem_stall ? WAIT_INIT : (wait_hold ? wait_cnt - 1'b1 : '0);
            if (if_id_en)
                valid_id <= if_valid && !if_id_flush;
            if (id_ex_en)
                valid_ex <= valid_id && !id_ex_flush;
            if (ex_mem_en)
                valid_mem <= valid_ex;
            if (mem_wb_en)
                valid_wb <= valid_mem;
            if (valid_wb && mem_wb_en)
                retired_cnt <= retired_cnt + 1'b1;
            if (lu_stall)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    pipe_ctrl_fwd #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs    (ex_rs1),
        .mem_rd(mem_rd),
        .wb_rd (wb_rd),
        .mem_wr(valid_mem && mem_reg_write),
        .wb_wr (valid_wb && wb_reg_write),
        .sel   (fwd_a)
    );

    pipe_ctrl_fwd #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs    (ex_rs2),
        .mem_rd(mem_rd),
        .wb_rd (wb_rd),
        .mem_wr(valid_mem && mem_reg_write),
        .wb_wr (valid_wb && wb_reg_write),
        .sel   (fwd_b)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: two controllers (MEM_LAT=3/CNT_W=32 and MEM_LAT=0/CNT_W=4) on shared stimulus,
// checked every cycle against a per-instruction behavioural model plus literal scenario checks.
module tb_pipe_ctrl;

    logic clk = 1'b0, arst_n = 1'b0, enable = 1'b0, if_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
    logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic mem_reg_write = 1'b0, wb_reg_write = 1'b0, mem_access = 1'b0;

    // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id_flush, id_ex_flush, fwd_a, fwd_b, valid id/ex/mem/wb}
    wire [14:0] o0, o1;
    wire [31:0] ret0, st0;
    wire [3:0]  ret1, st1;

    int pass_cnt = 0, total_cnt = 0;

    bit m_vid[2], m_vex[2], m_vmem[2], m_vwb[2], m_served[2];
    bit m_frz[2], m_br[2], m_lus[2], m_blk[2];
    int m_waited[2];
    int unsigned m_ret[2], m_stall[2];

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_ADDR_W(5), .MEM_LAT(3), .CNT_W(32)) dut_a (
        .clk(clk), .arst_n(arst_n), .enable(enable), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .mem_access(mem_access),
        .pc_en(o0[14]), .if_id_en(o0[13]), .id_ex_en(o0[12]), .ex_mem_en(o0[11]), .mem_wb_en(o0[10]),
        .if_id_flush(o0[9]), .id_ex_flush(o0[8]), .fwd_a(o0[7:6]), .fwd_b(o0[5:4]),
        .valid_id(o0[3]), .valid_ex(o0[2]), .valid_mem(o0[1]), .valid_wb(o0[0]),
        .retired_cnt(ret0), .stall_cnt(st0)
    );

    pipe_ctrl #(.REG_ADDR_W(5), .MEM_LAT(0), .CNT_W(4)) dut_b (
        .clk(clk), .arst_n(arst_n), .enable(enable), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .mem_access(mem_access),
        .pc_en(o1[14]), .if_id_en(o1[13]), .id_ex_en(o1[12]), .ex_mem_en(o1[11]), .mem_wb_en(o1[10]),
        .if_id_flush(o1[9]), .id_ex_flush(o1[8]), .fwd_a(o1[7:6]), .fwd_b(o1[5:4]),
        .valid_id(o1[3]), .valid_ex(o1[2]), .valid_mem(o1[1]), .valid_wb(o1[0]),
        .retired_cnt(ret1), .stall_cnt(st1)
    );

    function automatic int lat(int k);
        return k == 0 ? 3 : 0;
    endfunction

    function automatic logic [14:0] dut_out(int k);
        return k == 0 ? o0 : o1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Youngest-first search: the nearest older producer of rs wins.
    function automatic logic [1:0] fwd_model(int k, logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (m_vmem[k] && mem_reg_write && mem_rd == rs) return 2'b01;
        if (m_vwb[k] && wb_reg_write && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    // An instruction in MEM with a memory access must sit there for lat frozen cycles before it may leave.
    task automatic model_eval(int k);
        bit lu;
        m_blk[k] = lat(k) > 0 && !m_served[k] && (m_waited[k] > 0 || (m_vmem[k] && mem_access));
        m_frz[k] = !enable || m_blk[k];
        m_br[k]  = !m_frz[k] && m_vex[k] && ex_branch_taken;
        lu = !m_served[k] && m_vex[k] && ex_mem_read && m_vid[k] && ex_rd != 0 &&
             ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
        m_lus[k] = !m_frz[k] && !m_br[k] && lu;
    endtask

    function automatic logic [14:0] model_out(int k);
        logic adv;
        adv = !m_frz[k];
        return {adv && !m_lus[k], adv && !m_lus[k], adv, adv, adv, m_br[k], m_br[k] || m_lus[k],
                fwd_model(k, ex_rs1), fwd_model(k, ex_rs2), m_vid[k], m_vex[k], m_vmem[k], m_vwb[k]};
    endfunction

    task automatic model_update(int k);
        if (!enable) return;
        if (m_blk[k]) begin
            m_waited[k]++;
            if (m_waited[k] == lat(k)) m_served[k] = 1'b1;
        end else begin
            m_served[k] = 1'b0;
            m_waited[k] = 0;
            if (m_vwb[k]) m_ret[k]++;
            if (m_lus[k]) m_stall[k]++;
            m_vwb[k]  = m_vmem[k];
            m_vmem[k] = m_vex[k];
            m_vex[k]  = m_vid[k] && !(m_lus[k] || m_br[k]);
            if (!m_lus[k]) m_vid[k] = if_valid && !m_br[k];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            {m_vid[k], m_vex[k], m_vmem[k], m_vwb[k], m_served[k]} = '0;
            m_waited[k] = 0;
            m_ret[k] = 0;
            m_stall[k] = 0;
        end
    endtask

    // Called at a negedge; compares, crosses the posedge, returns at the next negedge.
    task automatic tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            chk($sformatf("outputs[%0d]", k), 32'(dut_out(k)), 32'(model_out(k)));
        end
        chk("retired_cnt[0]", ret0, m_ret[0]);
        chk("stall_cnt[0]", st0, m_stall[0]);
        chk("retired_cnt[1]", 32'(ret1), m_ret[1] % 16);
        chk("stall_cnt[1]", 32'(st1), m_stall[1] % 16);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge clk);
    endtask

    task automatic clr();
        {if_valid, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken} = '0;
        {mem_reg_write, wb_reg_write, mem_access} = '0;
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    endtask

    task automatic do_reset();
        enable = 1'b1;
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_outputs[0]", 32'(o0), 32'h7C00);
        chk("reset_outputs[1]", 32'(o1), 32'h7C00);
        chk("reset_retired", ret0, 0);
        chk("reset_stall", st0, 0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic prime(int n);
        clr();
        do_reset();
        if_valid = 1'b1;
        repeat (n) tick();
        clr();
    endtask

    task automatic randomize_inputs();
        enable          = $urandom_range(0, 9) != 0;
        if_valid        = $urandom_range(0, 3) != 0;
        id_rs1          = 5'($urandom_range(0, 3));
        id_rs2          = 5'($urandom_range(0, 3));
        ex_rs1          = 5'($urandom_range(0, 3));
        ex_rs2          = 5'($urandom_range(0, 3));
        ex_rd           = 5'($urandom_range(0, 3));
        mem_rd          = 5'($urandom_range(0, 3));
        wb_rd           = 5'($urandom_range(0, 3));
        id_uses_rs1     = 1'($urandom);
        id_uses_rs2     = 1'($urandom);
        ex_mem_read     = 1'($urandom);
        ex_branch_taken = $urandom_range(0, 4) == 0;
        mem_reg_write   = 1'($urandom);
        wb_reg_write    = 1'($urandom);
        mem_access      = $urandom_range(0, 3) == 0;
    endtask

    initial begin
        logic [3:0] sv;
        int unsigned sr, ss;
        @(negedge clk);
        // load-use: ld x5 in EX, add x6,x5,x1 in ID
        prime(2);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd1; id_uses_rs2 = 1'b1;
        #1;
        chk("lu_pc_en", 32'(o0[14]), 0);
        chk("lu_if_id_en", 32'(o0[13]), 0);
        chk("lu_id_ex_flush", 32'(o0[8]), 1);
        tick();
        clr();
        tick();
        ex_rs1 = 5'd5; wb_rd = 5'd5; wb_reg_write = 1'b1;
        #1;
        chk("lu_fwd_a", 32'(o0[7:6]), 2);
        chk("lu_stall_cnt", st0, 1);
        tick();
        // taken branch together with a load-use match
        prime(2);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1; if_valid = 1'b1;
        #1;
        chk("br_flushes", 32'(o0[9:8]), 3);
        chk("br_pc_en", 32'(o0[14]), 1);
        tick();
        clr();
        #1;
        chk("br_valid_id_ex", 32'(o0[3:2]), 0);
        chk("br_stall_cnt", st0, 0);
        tick();
        // memory latency: 3 frozen cycles then advance; no freeze at MEM_LAT=0
        prime(3);
        mem_access = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("memlat3_en[%0d]", i), 32'(o0[14:10]), i < 3 ? 0 : 32'h1F);
            chk($sformatf("memlat0_en[%0d]", i), 32'(o1[14:10]), 32'h1F);
            tick();
        end
        // forward priority
        prime(4);
        ex_rs1 = 5'd7; ex_rs2 = 5'd3; mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        #1;
        chk("fwd_mem_first", 32'(o0[7:6]), 1);
        chk("fwd_b_nomatch", 32'(o0[5:4]), 0);
        mem_rd = 5'd0;
        #1;
        chk("fwd_wb", 32'(o0[7:6]), 2);
        wb_rd = 5'd0;
        #1;
        chk("fwd_none", 32'(o0[7:6]), 0);
        tick();
        // reset in the middle of a memory wait
        prime(3);
        mem_access = 1'b1;
        tick();
        tick();
        #1;
        chk("memwait_frozen", 32'(o0[14:10]), 0);
        do_reset();
        clr();
        #1;
        chk("post_reset_run", 32'(o0[14:10]), 32'h1F);
        tick();
        // counter wrap with 17 retirements
        prime(0);
        if_valid = 1'b1;
        repeat (21) tick();
        #1;
        chk("wrap_retired4", 32'(ret1), 1);
        chk("retired32", ret0, 17);
        tick();
        // randomized traffic
        clr();
        do_reset();
        repeat (2000) begin
            randomize_inputs();
            tick();
        end
        // enable low for 5 cycles
        randomize_inputs();
        enable = 1'b0;
        sv = {m_vid[0], m_vex[0], m_vmem[0], m_vwb[0]};
        sr = m_ret[0];
        ss = m_stall[0];
        repeat (5) begin
            #1;
            chk("hold_en_flush", 32'(o0[14:8]), 0);
            chk("hold_valid", 32'(o0[3:0]), 32'(sv));
            chk("hold_retired", ret0, sr);
            chk("hold_stall", st0, ss);
            tick();
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
